zap_copro_regf_arbiter: RTL and testbench

//  Sequences coprocessor transfers (MRC/MCR-style) into the ZAP register file.
//  A coprocessor raises a 4-phase request. The block then:
//   - stalls the pipeline front end;
//   - waits for writeback to drain with no exception pending;
//   - drives the register file coprocessor port for exactly one cycle;
//   - for reads, captures the registered read data and acks.

---
 rtl/zap_copro_regf_arbiter.sv | 149 ++++++++++++++
 tb/tb_zap_copro_regf_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_copro_regf_arbiter.sv
// Sequences coprocessor MRC/MCR transfers onto the register file coprocessor
// port: stall the front end, wait for a quiet writeback, access once, then ack.
module zap_copro_regf_arbiter #(
    parameter int PHY_REGS     = 46,
    parameter int RAZ_IDX      = 45,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    // Coprocessor side (4-phase handshake)
    input  logic                        i_cp_req,
    input  logic                        i_cp_wr,
    input  logic [$clog2(PHY_REGS)-1:0] i_cp_index,
    input  logic [31:0]                 i_cp_wdata,
    output logic                        o_cp_ack,
    output logic                        o_cp_err,
    output logic [31:0]                 o_cp_rdata,
    // Pipeline status
    input  logic                        i_wb_valid,
    input  logic                        i_intr_pending,
    input  logic                        i_clear_from_writeback,
    output logic                        o_stall,
    // Register file coprocessor port
    output logic                        o_copro_reg_en,
    output logic [$clog2(PHY_REGS)-1:0] o_copro_reg_wr_index,
    output logic [$clog2(PHY_REGS)-1:0] o_copro_reg_rd_index,
    output logic [31:0]                 o_copro_reg_wr_data,
    input  logic [31:0]                 i_copro_reg_rd_data_ff
);

    localparam int IW = $clog2(PHY_REGS);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ACCESS,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q;
    logic [IW-1:0]   index_q;
    logic [31:0]     wdata_q;
    logic            err_q;
    logic [31:0]     rdata_q;

    logic quiet;
    logic index_bad;

    assign quiet     = !i_wb_valid && !i_intr_pending && !i_clear_from_writeback;
    // Extra bit so an index space that exactly fills IW bits never reads as bad.
    assign index_bad = {1'b0, i_cp_index} >= (IW+1)'(PHY_REGS);

    // NOTE: every output and next-state variable gets a default before the case,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        o_stall              = 1'b0;
        o_cp_ack             = 1'b0;
        o_copro_reg_en       = 1'b0;
        o_copro_reg_wr_index = '0;
        o_copro_reg_rd_index = '0;
        o_copro_reg_wr_data  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (i_cp_req) begin
                    cnt_d   = '0;
                    state_d = index_bad ? S_DONE : S_DRAIN;
                end
            end

            S_DRAIN: begin
                o_stall = 1'b1;
                if (quiet) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DRAIN_CYCLES - 1)) state_d = S_ACCESS;
                end else begin
                    cnt_d = '0;
                end
            end

            S_ACCESS: begin
                o_stall = 1'b1;
                // An exception wins the register file this cycle; retry after a fresh drain.
                if (i_intr_pending) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    o_copro_reg_en       = 1'b1;
                    o_copro_reg_rd_index = index_q;
                    if (wr_q) begin
                        o_copro_reg_wr_index = index_q;
                        o_copro_reg_wr_data  = wdata_q;
                        state_d              = S_DONE;
                    end else begin
                        // Port always writes; steer the read's write half into RAZ.
                        o_copro_reg_wr_index = IW'(RAZ_IDX);
                        state_d              = S_CAPTURE;
                    end
                end
            end

            S_CAPTURE: begin
                o_stall = 1'b1;
                state_d = S_DONE;
            end

            S_DONE: begin
                o_cp_ack = 1'b1;
                if (!i_cp_req) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign o_cp_err   = (state_q == S_DONE) && err_q;
    assign o_cp_rdata = rdata_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            index_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && i_cp_req) begin
                wr_q    <= i_cp_wr;
                index_q <= i_cp_index;
                wdata_q <= i_cp_wdata;
                err_q   <= index_bad;
            end
            if (state_q == S_CAPTURE) rdata_q <= i_copro_reg_rd_data_ff;
        end
    end

endmodule

// File: tb/tb_zap_copro_regf_arbiter.sv
// Directed bench for zap_copro_regf_arbiter with a small register file model
// wired to the coprocessor port.
module tb_zap_copro_regf_arbiter;

    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          cp_req, cp_wr;
    logic [IW-1:0] cp_index;
    logic [31:0]   cp_wdata;
    logic          cp_ack, cp_err;
    logic [31:0]   cp_rdata;
    logic          wb_valid, intr_pending, clear_wb;
    logic          stall;
    logic          en;
    logic [IW-1:0] wr_index, rd_index;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data_ff;

    logic          init_rf;
    logic [31:0]   rf [64];
    int            en_cnt = 0;
    int            ack_rises = 0;
    logic          ack_d = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    zap_copro_regf_arbiter dut (
        .i_clk                  (clk),
        .i_reset                (i_reset),
        .i_cp_req               (cp_req),
        .i_cp_wr                (cp_wr),
        .i_cp_index             (cp_index),
        .i_cp_wdata             (cp_wdata),
        .o_cp_ack               (cp_ack),
        .o_cp_err               (cp_err),
        .o_cp_rdata             (cp_rdata),
        .i_wb_valid             (wb_valid),
        .i_intr_pending         (intr_pending),
        .i_clear_from_writeback (clear_wb),
        .o_stall                (stall),
        .o_copro_reg_en         (en),
        .o_copro_reg_wr_index   (wr_index),
        .o_copro_reg_rd_index   (rd_index),
        .o_copro_reg_wr_data    (wr_data),
        .i_copro_reg_rd_data_ff (rd_data_ff)
    );

    // Register file model: port write on enable, registered read every cycle.
    always @(posedge clk) begin
        if (init_rf) begin
            for (int i = 0; i < 64; i++) rf[i] <= (i == 7) ? 32'h1234_5678 : 32'h0;
        end else if (en) begin
            rf[wr_index] <= wr_data;
        end
        rd_data_ff <= rf[rd_index];
    end

    always @(negedge clk) begin
        if (en) en_cnt <= en_cnt + 1;
        if (cp_ack && !ack_d) ack_rises <= ack_rises + 1;
        ack_d <= cp_ack;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [IW-1:0] idx, input logic [31:0] data);
        cp_req   = 1'b1;
        cp_wr    = wr;
        cp_index = idx;
        cp_wdata = data;
    endtask

    // Ticks until the port enable shows, bounded; n is the number of ticks taken.
    task automatic wait_en(input int budget, output int n);
        n = 0;
        while (en !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    int n, en0, ack0;

    initial begin
        i_reset      = 1'b1;
        init_rf      = 1'b1;
        cp_req       = 1'b0;
        cp_wr        = 1'b0;
        cp_index     = '0;
        cp_wdata     = '0;
        wb_valid     = 1'b0;
        intr_pending = 1'b0;
        clear_wb     = 1'b0;
        tick();
        tick();
        check("rst_ack",   32'(cp_ack),   32'd0);
        check("rst_err",   32'(cp_err),   32'd0);
        check("rst_stall", 32'(stall),    32'd0);
        check("rst_en",    32'(en),       32'd0);
        check("rst_rdata", cp_rdata,      32'd0);
        check("rst_wridx", 32'(wr_index), 32'd0);
        i_reset = 1'b0;
        init_rf = 1'b0;
        tick();

        // 1: write idx 3, en five cycles after the IDLE cycle that saw req.
        drive_req(1'b1, 6'd3, 32'hDEAD_BEEF);
        #1;
        check("t1_idle_stall", 32'(stall), 32'd0);
        en0 = en_cnt; ack0 = ack_rises;
        wait_en(20, n);
        check("t1_latency", 32'(n),        32'd5);
        check("t1_wridx",   32'(wr_index), 32'd3);
        check("t1_rdidx",   32'(rd_index), 32'd3);
        check("t1_wrdata",  wr_data,       32'hDEAD_BEEF);
        check("t1_stall",   32'(stall),    32'd1);
        tick();
        check("t1_ack",     32'(cp_ack),   32'd1);
        check("t1_err",     32'(cp_err),   32'd0);
        check("t1_en_off",  32'(en),       32'd0);
        check("t1_done_st", 32'(stall),    32'd0);
        check("t1_rf3",     rf[3],         32'hDEAD_BEEF);
        tick();
        check("t1_ack_hold", 32'(cp_ack), 32'd1);
        cp_req = 1'b0;
        tick();
        check("t1_ack_drop", 32'(cp_ack), 32'd0);
        check("t1_en_once",  32'(en_cnt - en0), 32'd1);

        // 2: read idx 7; write half must land on RAZ with zero data.
        drive_req(1'b0, 6'd7, 32'hAAAA_5555);
        wait_en(20, n);
        check("t2_latency", 32'(n),        32'd5);
        check("t2_wridx",   32'(wr_index), 32'd45);
        check("t2_wrdata",  wr_data,       32'd0);
        check("t2_rdidx",   32'(rd_index), 32'd7);
        tick();
        check("t2_cap_ack",   32'(cp_ack), 32'd0);
        check("t2_cap_stall", 32'(stall),  32'd1);
        tick();
        check("t2_ack",   32'(cp_ack), 32'd1);
        check("t2_rdata", cp_rdata,    32'h1234_5678);
        check("t2_rf45",  rf[45],      32'd0);
        cp_req = 1'b0;
        tick();
        check("t2_rdata_hold", cp_rdata, 32'h1234_5678);

        // 3: writeback pulse at cnt=2 restarts the drain.
        drive_req(1'b1, 6'd5, 32'h0BAD_F00D);
        tick();
        tick();
        tick();
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        check("t3_no_en", 32'(en), 32'd0);
        wait_en(20, n);
        check("t3_restart", 32'(n), 32'd4);
        check("t3_wridx",   32'(wr_index), 32'd5);
        tick();
        check("t3_ack", 32'(cp_ack), 32'd1);
        check("t3_rf5", rf[5],       32'h0BAD_F00D);
        cp_req = 1'b0;
        tick();

        // 4: exception in ACCESS suppresses the port and retries exactly once.
        en0 = en_cnt; ack0 = ack_rises;
        drive_req(1'b1, 6'd9, 32'hCAFE_0009);
        repeat (5) tick();
        intr_pending = 1'b1;
        #1;
        check("t4_en_blocked", 32'(en),    32'd0);
        check("t4_stall",      32'(stall), 32'd1);
        tick();
        intr_pending = 1'b0;
        #1;
        check("t4_no_ack", 32'(cp_ack), 32'd0);
        wait_en(20, n);
        check("t4_retry_lat", 32'(n),        32'd4);
        check("t4_wridx",     32'(wr_index), 32'd9);
        tick();
        check("t4_ack", 32'(cp_ack), 32'd1);
        check("t4_rf9", rf[9],       32'hCAFE_0009);
        tick();
        cp_req = 1'b0;
        tick();
        check("t4_en_once",  32'(en_cnt - en0),     32'd1);
        check("t4_ack_once", 32'(ack_rises - ack0), 32'd1);

        // 5: out-of-range index errors out without touching the port.
        en0 = en_cnt;
        drive_req(1'b1, 6'd50, 32'h5555_AAAA);
        tick();
        check("t5_ack",   32'(cp_ack), 32'd1);
        check("t5_err",   32'(cp_err), 32'd1);
        check("t5_stall", 32'(stall),  32'd0);
        tick();
        check("t5_err_hold", 32'(cp_err), 32'd1);
        cp_req = 1'b0;
        tick();
        check("t5_ack_drop", 32'(cp_ack), 32'd0);
        check("t5_err_drop", 32'(cp_err), 32'd0);
        check("t5_no_en",    32'(en_cnt - en0), 32'd0);

        // 6: reset during CAPTURE abandons the read; the next one completes.
        drive_req(1'b0, 6'd3, 32'd0);
        wait_en(20, n);
        check("t6_latency", 32'(n), 32'd5);
        tick();
        check("t6_cap_stall", 32'(stall), 32'd1);
        ack0 = ack_rises;
        i_reset = 1'b1;
        cp_req  = 1'b0;
        tick();
        check("t6_rst_ack",   32'(cp_ack), 32'd0);
        check("t6_rst_stall", 32'(stall),  32'd0);
        check("t6_rst_en",    32'(en),     32'd0);
        check("t6_rst_rdata", cp_rdata,    32'd0);
        i_reset = 1'b0;
        tick();
        check("t6_no_ack", 32'(ack_rises - ack0), 32'd0);
        drive_req(1'b0, 6'd3, 32'd0);
        wait_en(20, n);
        check("t6_re_latency", 32'(n), 32'd5);
        tick();
        tick();
        check("t6_re_ack",   32'(cp_ack), 32'd1);
        check("t6_re_rdata", cp_rdata,    32'hDEAD_BEEF);
        cp_req = 1'b0;
        tick();
        check("t6_idle", 32'(cp_ack), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
